iob_iob2wishbone_pipe: RTL

//   Pipelined IOb-to-Wishbone B4 bridge. Buffers IOb requests in a command FIFO and issues them

---
 rtl/iob_iob2wishbone_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/iob_iob2wishbone_pipe.sv
// Pipelined IOb-to-Wishbone B4 bridge: command FIFO, in-order retirement, up to MAX_OUTST in flight.
// Optional bus-abort watchdog is compiled in with `define IOB2WB_TIMEOUT_EN.
module iob_iob2wishbone_pipe #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FIFO_AW        = 2,
  parameter int MAX_OUTST      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                ready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                error_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic [DATA_W-1:0]   wb_data_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int OW    = $clog2(MAX_OUTST + 1);
  localparam int QI_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [ADDR_W-1:0]  fifo_addr [DEPTH];
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [SEL_W-1:0]   fifo_sel  [DEPTH];
  logic               fifo_we   [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [OW-1:0]        outst;
  logic                 outst_zero;
  logic                 outst_room;
  logic [MAX_OUTST-1:0] trk_we;
  logic [MAX_OUTST-1:0] trk_nxt;
  logic [QI_W-1:0]      trk_idx;

  logic bus_resp;
  logic resp_ret;
  logic force_ret;
  logic retire;
  logic retire_err;
  logic retire_read;
  logic abort;

  logic              rd_vld_p1;
  logic              err_vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  // Full exactly when the count MSB is set, since the count never exceeds DEPTH.
  assign fifo_empty = (fifo_cnt == '0);
  assign ready_o    = ~fifo_cnt[FIFO_AW];
  assign push       = valid_i & ready_o;

  assign outst_zero = (outst == '0);
  assign outst_room = (outst < OW'(MAX_OUTST));

  assign wb_stb_o    = ~fifo_empty & outst_room & ~abort;
  assign wb_cyc_o    = wb_stb_o | (~outst_zero & ~abort);
  assign pop         = wb_stb_o & ~wb_stall_i;
  assign wb_addr_o   = fifo_empty ? '0 : fifo_addr[rd_ptr];
  assign wb_data_o   = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign wb_select_o = fifo_empty ? '0 : fifo_sel[rd_ptr];
  assign wb_we_o     = ~fifo_empty & fifo_we[rd_ptr];

  // An abort drains one outstanding transfer per cycle and ignores the bus meanwhile.
  assign bus_resp    = wb_ack_i | wb_err_i;
  assign resp_ret    = bus_resp & ~outst_zero & ~abort;
  assign force_ret   = abort & ~outst_zero;
  assign retire      = resp_ret | force_ret;
  assign retire_err  = force_ret | (resp_ret & wb_err_i);
  assign retire_read = ~trk_we[0];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= address_i;
      fifo_data[wr_ptr] <= wdata_i;
      fifo_sel[wr_ptr]  <= (|wstrb_i) ? wstrb_i : {SEL_W{1'b1}};
      fifo_we[wr_ptr]   <= |wstrb_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Tracking queue: entry 0 is the oldest outstanding transfer; retirement shifts it out.
  always_comb begin
    trk_idx = retire ? QI_W'(outst - OW'(1)) : QI_W'(outst);
    trk_nxt = trk_we;
    if (retire) trk_nxt = trk_we >> 1;
    if (pop)    trk_nxt[trk_idx] = fifo_we[rd_ptr];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      outst  <= '0;
      trk_we <= '0;
    end else begin
      trk_we <= trk_nxt;
      case ({pop, retire})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

`ifdef IOB2WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          to_run;

  assign to_run = ~outst_zero & ~bus_resp & ~abort;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      to_cnt <= '0;
      abort  <= 1'b0;
    end else if (abort) begin
      to_cnt <= '0;
      if (outst <= OW'(1)) abort <= 1'b0;
    end else if (to_run) begin
      if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt <= '0;
        abort  <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end
`else
  // No watchdog: the bridge waits indefinitely for ack/err.
  assign abort = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // Retire stage: IOb response registered one cycle after ack/err.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_vld_p1  <= 1'b0;
      err_vld_p1 <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      rd_vld_p1  <= retire & retire_read;
      err_vld_p1 <= retire & retire_err;
      if (retire & retire_read) rdata_p1 <= retire_err ? '0 : wb_data_i;
    end
  end

  assign rvalid_o = rd_vld_p1;
  assign error_o  = err_vld_p1;
  assign rdata_o  = rdata_p1;

endmodule
